// File: rtl/array_dot_accum_if.sv
// array_dot_accum_if
// Beat bus into the dot-product accumulator and the result bus out of it.
//   in_valid  : a beat is present on products
//   in_last   : the beat closes the current group (meaningful only with in_valid)
//   products  : n signed W-bit lane products from the array multiplier
//   out_valid : a group result is present (consumer qualifies it with en)
//   out_sum   : saturated signed group sum, W bits
//   out_ovf   : the group saturated or overflowed its beat count
//   out_count : number of beats in the group, saturating at 2^CW-1
// The master modport is the producer/consumer side; the slave modport is the accumulator.
interface array_dot_accum_if #(
  parameter int n  = 6,
  parameter int W  = 36,
  parameter int CW = 8
);
  logic                  in_valid;
  logic                  in_last;
  logic [n-1:0][W-1:0]   products;
  logic                  out_valid;
  logic [W-1:0]          out_sum;
  logic                  out_ovf;
  logic [CW-1:0]         out_count;

  modport master (
    output in_valid, in_last, products,
    input  out_valid, out_sum, out_ovf, out_count
  );

  modport slave (
    input  in_valid, in_last, products,
    output out_valid, out_sum, out_ovf, out_count
  );
endinterface

// File: rtl/array_dot_accum.sv
// array_dot_accum
// Reduces the n lane products of each accepted beat through a registered
// signed adder tree and accumulates successive beats into one dot product.
// When the beat marked last has drained, it emits a W-bit saturated sum,
// an overflow flag and the group's beat count.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, takes priority over en
//   en  : global advance; every register holds while en=0
//   bus : array_dot_accum_if slave modport (beat in, result out)
// Latency: a last beat accepted at edge E0 produces out_valid at edge E0+D+1,
// with D = ceil(log2 n); stalled cycles add to that one for one.
module array_dot_accum #(
  parameter int n     = 6,
  parameter int W     = 36,
  parameter int GUARD = 8,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  array_dot_accum_if.slave bus
);

  localparam int D  = $clog2(n);
  localparam int NP = 1 << D;
  localparam int TW = W + D;
  localparam int AW = W + D + GUARD;

  localparam logic signed [AW-1:0] SMAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  // Level 0 holds the registered, sign-extended lanes padded with zeros up to
  // a power of two. Adding a zero partner is how an odd leftover operand
  // passes through a level unchanged; the zero slots are constant registers.
  logic signed [TW-1:0] pad  [NP];
  logic signed [TW-1:0] tree [D+1][NP];
  logic [D:0]           vld;
  logic [D:0]           lst;

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] s;
  logic [CW-1:0]        cnt;
  logic                 cnt_max;
  logic                 sat_hi;
  logic                 sat_lo;
  logic [W-1:0]         clamped;

  logic                 out_valid_r;
  logic [W-1:0]         out_sum_r;
  logic                 out_ovf_r;
  logic [CW-1:0]        out_count_r;

  for (genvar i = 0; i < NP; i++) begin : g_pad
    if (i < n) begin : g_lane
      assign pad[i] = TW'($signed(bus.products[i]));
    end else begin : g_zero
      assign pad[i] = '0;
    end
  end

  // Input register plus D adder levels; each level sums adjacent pairs of the
  // previous one, so the complete tree sum emerges in tree[D][0]. The
  // valid/last flags shift alongside so they line up with each level.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l <= D; l++) begin
        for (int j = 0; j < NP; j++) begin
          tree[l][j] <= '0;
        end
      end
      vld <= '0;
      lst <= '0;
    end else if (en) begin
      for (int j = 0; j < NP; j++) begin
        tree[0][j] <= pad[j];
      end
      for (int l = 1; l <= D; l++) begin
        for (int j = 0; j < NP / 2; j++) begin
          tree[l][j] <= tree[l-1][2*j] + tree[l-1][2*j+1];
        end
      end
      vld <= {vld[D-1:0], bus.in_valid};
      lst <= {lst[D-1:0], bus.in_valid & bus.in_last};
    end
  end

  // Running sum including the beat leaving the tree, and its clamp to W bits.
  always_comb begin
    s       = acc + AW'(tree[D][0]);
    cnt_max = (cnt == {CW{1'b1}});
    sat_hi  = (s > SMAX);
    sat_lo  = (s < SMIN);
    clamped = s[W-1:0];
    if (sat_hi) begin
      clamped = SMAX[W-1:0];
    end else if (sat_lo) begin
      clamped = SMIN[W-1:0];
    end
  end

  // Accumulate non-last beats; on the last beat publish the clamped result and
  // clear acc/cnt so the very next beat opens a fresh group. out_valid is a
  // one-enabled-cycle pulse and simply holds through stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      cnt         <= '0;
      out_valid_r <= 1'b0;
      out_sum_r   <= '0;
      out_ovf_r   <= 1'b0;
      out_count_r <= '0;
    end else if (en) begin
      if (vld[D] && lst[D]) begin
        out_sum_r   <= clamped;
        out_ovf_r   <= sat_hi | sat_lo | cnt_max;
        out_count_r <= cnt_max ? cnt : cnt + 1'b1;
        out_valid_r <= 1'b1;
        acc         <= '0;
        cnt         <= '0;
      end else if (vld[D]) begin
        acc         <= s;
        cnt         <= cnt_max ? cnt : cnt + 1'b1;
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = out_sum_r;
  assign bus.out_ovf   = out_ovf_r;
  assign bus.out_count = out_count_r;

endmodule

// File: tb/tb_array_dot_accum.sv
// tb_array_dot_accum
// Directed bench for array_dot_accum: drives beats one enabled cycle at a
// time, logs every delivered result (out_valid && en) with the edge it
// appeared on, and compares against hand-computed sums, counts and latencies.
module tb_array_dot_accum;

  localparam int N  = 6;
  localparam int W  = 36;
  localparam int CW = 8;

  typedef logic [N-1:0][W-1:0] beat_t;

  typedef struct {
    logic [W-1:0]  sum;
    logic          ovf;
    logic [CW-1:0] cnt;
    int            at;
  } pulse_t;

  logic clk;
  logic rst;
  logic en;

  array_dot_accum_if #(.n(N), .W(W), .CW(CW)) bus ();

  array_dot_accum #(.n(N), .W(W), .GUARD(8), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  int     vectors;
  int     miscompares;
  int     edges;
  int     lastEdge;
  int     a0;
  pulse_t q[$];
  pulse_t p;

  localparam longint SMAXV = 64'sd34359738367;
  localparam longint SMINV = -64'sd34359738368;

  // Free-running clock and a count of rising edges for latency checks.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial edges = 0;
  always @(posedge clk) edges <= edges + 1;

  // Record each delivered result on the falling edge, where outputs and en are stable.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1 && en === 1'b1) begin
      p.sum = bus.out_sum;
      p.ovf = bus.out_ovf;
      p.cnt = bus.out_count;
      p.at  = edges;
      q.push_back(p);
    end
  end

  function automatic beat_t fill(input logic signed [W-1:0] v);
    beat_t b;
    for (int i = 0; i < N; i++) b[i] = v;
    return b;
  endfunction

  // Present one cycle of inputs and step past the rising edge that samples them.
  task automatic applyStimulus(input logic r, input logic e, input logic v,
                               input logic l, input beat_t b);
    rst          = r;
    en           = e;
    bus.in_valid = v;
    bus.in_last  = l;
    bus.products = b;
    lastEdge     = edges + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
  endtask

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Compare logged pulse idx against the expected result and arrival edge.
  task automatic checkPulse(input string tag, input int idx, input longint sum,
                            input int ovf, input int cnt, input int at);
    if (idx < q.size()) begin
      checkOutput({tag, ".sum"},   64'($signed(q[idx].sum)), sum);
      checkOutput({tag, ".ovf"},   64'(q[idx].ovf), 64'(ovf));
      checkOutput({tag, ".count"}, 64'(q[idx].cnt), 64'(cnt));
      checkOutput({tag, ".edge"},  64'(q[idx].at), 64'(at));
    end else begin
      checkOutput({tag, ".present"}, 64'(q.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    beat_t seq6;
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < N; i++) seq6[i] = W'(i + 1);

    // Reset for two cycles, then idle: everything zero and no pulse.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    idle(8);
    checkOutput("rst.out_valid", 64'(bus.out_valid), 0);
    checkOutput("rst.out_sum",   64'(bus.out_sum), 0);
    checkOutput("rst.out_ovf",   64'(bus.out_ovf), 0);
    checkOutput("rst.out_count", 64'(bus.out_count), 0);
    checkOutput("rst.pulses",    64'(q.size()), 0);

    // Single beat 1..6 -> 21, four edges after acceptance.
    q.delete();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, seq6);
    a0 = lastEdge;
    idle(8);
    checkOutput("single.pulses", 64'(q.size()), 1);
    checkPulse("single", 0, 21, 0, 1, a0 + 4);

    // 1, (two stalled cycles with a decoy beat), -2, 10 last -> 54 over 3 beats.
    q.delete();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, fill(1));
    a0 = lastEdge;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, fill(100));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, fill(100));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, fill(-2));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, fill(10));
    idle(10);
    checkOutput("stall.pulses", 64'(q.size()), 1);
    checkPulse("stall", 0, 54, 0, 3, a0 + 8);

    // Stall while the group drains: latency grows by the three stalled cycles.
    q.delete();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, fill(3));
    a0 = lastEdge;
    idle(2);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    idle(8);
    checkOutput("drain.pulses", 64'(q.size()), 1);
    checkPulse("drain", 0, 18, 0, 1, a0 + 7);
    checkOutput("hold.out_valid", 64'(bus.out_valid), 0);
    checkOutput("hold.out_sum",   64'($signed(bus.out_sum)), 18);

    // Positive and negative saturation over two-beat groups.
    q.delete();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, fill(36'h7_FFFF_FFFF));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, fill(36'h7_FFFF_FFFF));
    a0 = lastEdge;
    idle(8);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, fill(36'h8_0000_0000));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, fill(36'h8_0000_0000));
    idle(8);
    checkOutput("sat.pulses", 64'(q.size()), 2);
    checkPulse("sat_pos", 0, SMAXV, 1, 2, a0 + 4);
    checkPulse("sat_neg", 1, SMINV, 1, 2, a0 + 14);

    // Back-to-back single-beat groups with no carry-over.
    q.delete();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, fill(1));
    a0 = lastEdge;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, fill(-1));
    idle(8);
    checkOutput("b2b.pulses", 64'(q.size()), 2);
    checkPulse("b2b_first", 0, 6, 0, 1, a0 + 4);
    checkPulse("b2b_second", 1, -6, 0, 1, a0 + 5);

    // Reset mid-group drops the two earlier beats.
    q.delete();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, fill(5));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, fill(5));
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, fill(5));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, fill(7));
    a0 = lastEdge;
    idle(8);
    checkOutput("midrst.pulses", 64'(q.size()), 1);
    checkPulse("midrst", 0, 42, 0, 1, a0 + 4);

    // Beat count boundary: 255 beats fit, 256 saturate the count and flag it.
    q.delete();
    for (int i = 0; i < 255; i++)
      applyStimulus(1'b0, 1'b1, 1'b1, (i == 254), fill(1));
    a0 = lastEdge;
    idle(8);
    for (int i = 0; i < 256; i++)
      applyStimulus(1'b0, 1'b1, 1'b1, (i == 255), fill(1));
    idle(8);
    checkOutput("cnt.pulses", 64'(q.size()), 2);
    checkPulse("cnt255", 0, 1530, 0, 255, a0 + 4);
    checkPulse("cnt256", 1, 1536, 1, 255, a0 + 4 + 8 + 256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
